pkt_dedup: RTL and testbench

PKT_DEDUP -- requirements
Module: pkt_dedup

---
 rtl/pkt_dedup.sv | 121 ++++++++++++
 tb/tb_pkt_dedup.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_dedup.sv
// Streaming de-duplicator for sorted packets: drops words equal to the previous
// accepted word of the same packet and re-marks SOP/EOP on the forwarded words.
module pkt_dedup #(
    parameter int DWIDTH      = 32,
    parameter int MAX_PKT_LEN = 32,
    localparam int CW         = $clog2(MAX_PKT_LEN) + 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic [CW-1:0]     drop_cnt_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] h_data;
    logic              h_sop;
    logic [CW-1:0]     dup_cnt;

    logic out_free;
    logic acc;
    logic push;
    logic push_eop;

    always_comb begin
        out_free = !src_valid_o || src_ready_i;
        unique case (state)
            IDLE:    snk_ready_o = 1'b1;
            ACCUM:   snk_ready_o = out_free;
            default: snk_ready_o = 1'b0;
        endcase
        acc      = snk_valid_i && snk_ready_o;
        push     = 1'b0;
        push_eop = 1'b0;
        // In ACCUM an accepted word already implies out_free, so a push never overwrites a stalled word.
        if (state == ACCUM && acc && (snk_startofpacket_i || snk_data_i != h_data)) begin
            push     = 1'b1;
            push_eop = snk_startofpacket_i;
        end else if (state == FLUSH && out_free) begin
            push     = 1'b1;
            push_eop = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state               <= IDLE;
            h_data              <= '0;
            h_sop               <= 1'b0;
            dup_cnt             <= '0;
            src_valid_o         <= 1'b0;
            src_data_o          <= '0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            drop_cnt_o          <= '0;
            err_o               <= 1'b0;
        end else begin
            err_o <= 1'b0;

            if (push) begin
                src_valid_o         <= 1'b1;
                src_data_o          <= h_data;
                src_startofpacket_o <= h_sop;
                src_endofpacket_o   <= push_eop;
            end else if (out_free) begin
                src_valid_o <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (acc && snk_startofpacket_i) begin
                        h_data  <= snk_data_i;
                        h_sop   <= 1'b1;
                        dup_cnt <= '0;
                        state   <= snk_endofpacket_i ? FLUSH : ACCUM;
                    end
                end
                ACCUM: begin
                    if (acc) begin
                        if (snk_startofpacket_i) begin
                            drop_cnt_o <= dup_cnt;
                            err_o      <= 1'b1;
                            h_data     <= snk_data_i;
                            h_sop      <= 1'b1;
                            dup_cnt    <= '0;
                        end else if (snk_data_i == h_data) begin
                            if (dup_cnt != '1) dup_cnt <= dup_cnt + 1'b1;
                        end else begin
                            h_data <= snk_data_i;
                            h_sop  <= 1'b0;
                        end
                        if (snk_endofpacket_i) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        drop_cnt_o <= dup_cnt;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_dedup.sv
// Self-checking bench for pkt_dedup: fixed vectors, directed corner sequences
// and randomized packets checked against a list-level dedup model.
module tb_pkt_dedup;
    localparam int DW = 32;
    localparam int ML = 32;
    localparam int CW = $clog2(ML) + 1;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic [DW-1:0] snk_data_i;
    logic          snk_startofpacket_i, snk_endofpacket_i, snk_valid_i, snk_ready_o;
    logic [DW-1:0] src_data_o;
    logic          src_startofpacket_o, src_endofpacket_o, src_valid_o, src_ready_i;
    logic [CW-1:0] drop_cnt_o;
    logic          err_o;

    always #5 clk_i = ~clk_i;

    pkt_dedup #(.DWIDTH(DW), .MAX_PKT_LEN(ML)) dut (
        .clk_i(clk_i), .srst_i(srst_i),
        .snk_data_i(snk_data_i), .snk_startofpacket_i(snk_startofpacket_i),
        .snk_endofpacket_i(snk_endofpacket_i), .snk_valid_i(snk_valid_i),
        .snk_ready_o(snk_ready_o),
        .src_data_o(src_data_o), .src_startofpacket_o(src_startofpacket_o),
        .src_endofpacket_o(src_endofpacket_o), .src_valid_o(src_valid_o),
        .src_ready_i(src_ready_i),
        .drop_cnt_o(drop_cnt_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } beat_t;

    typedef struct {
        int            len;
        logic [DW-1:0] d [8];
        int            olen;
        logic [DW-1:0] o [8];
        int            drop;
        int            mode;
    } vec_t;

    int            n_chk = 0, n_fail = 0, err_cnt = 0, rdy_mode = 0;
    beat_t         rcv[$];
    beat_t         exp_q[$];
    logic [DW-1:0] pkt_q[$];
    int            exp_drop;
    vec_t          tbl[6];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference: keep the first word of every run of equal values, mark ends, count the rest.
    task automatic build_model();
        int d;
        exp_q.delete();
        foreach (pkt_q[i])
            if (i == 0 || pkt_q[i] != pkt_q[i-1]) exp_q.push_back('{d: pkt_q[i], s: 1'b0, e: 1'b0});
        exp_q[0].s = 1'b1;
        exp_q[exp_q.size()-1].e = 1'b1;
        d = pkt_q.size() - exp_q.size();
        exp_drop = (d > (2**CW - 1)) ? (2**CW - 1) : d;
    endtask

    initial begin
        src_ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0:       src_ready_i = 1'b1;
                1:       src_ready_i = 1'($urandom_range(0, 1));
                default: src_ready_i = !src_ready_i;
            endcase
        end
    end

    initial begin
        beat_t pb;
        logic  ps, pr, pv;
        ps = 1'b0; pr = 1'b1; pv = 1'b0; pb = '0;
        forever begin
            @(negedge clk_i);
            if (!srst_i && err_o) err_cnt++;
            if (ps && !srst_i && !pr)
                check("stall_hold", 64'({src_data_o, src_startofpacket_o, src_endofpacket_o, src_valid_o}),
                      64'({pb, pv}));
            if (!srst_i && src_valid_o && src_ready_i)
                rcv.push_back('{d: src_data_o, s: src_startofpacket_o, e: src_endofpacket_o});
            ps = src_valid_o && !src_ready_i;
            pb = '{d: src_data_o, s: src_startofpacket_o, e: src_endofpacket_o};
            pv = src_valid_o;
            pr = srst_i;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_word(input logic [DW-1:0] d, input logic s, input logic e);
        logic acc;
        int   n;
        acc = 1'b0; n = 0;
        snk_data_i = d; snk_startofpacket_i = s; snk_endofpacket_i = e; snk_valid_i = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = snk_ready_o;
            @(posedge clk_i); #1;
            n++;
        end
        snk_valid_i = 1'b0;
        check("snk_accept", 64'(acc), 64'(1));
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (rcv.size() < n && c < 1000) begin
            @(posedge clk_i); #1;
            c++;
        end
    endtask

    task automatic run_pkt(input string nm);
        rcv.delete();
        foreach (pkt_q[i]) begin
            send_word(pkt_q[i], i == 0, i == pkt_q.size() - 1);
            if (rdy_mode == 1) repeat ($urandom_range(0, 1)) begin @(posedge clk_i); #1; end
        end
        wait_out(exp_q.size());
        check({nm, "_count"}, 64'(rcv.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            if (i < rcv.size()) check({nm, "_beat"}, 64'(rcv[i]), 64'(exp_q[i]));
        check({nm, "_drop"}, 64'(drop_cnt_o), 64'(exp_drop));
    endtask

    initial begin
        int v, len, e0;

        tbl[0] = '{len: 7, d: '{1,2,2,3,3,3,7,0}, olen: 4, o: '{1,2,3,7,0,0,0,0}, drop: 3, mode: 0};
        tbl[1] = '{len: 4, d: '{5,5,5,5,0,0,0,0}, olen: 1, o: '{5,0,0,0,0,0,0,0}, drop: 3, mode: 0};
        tbl[2] = '{len: 1, d: '{9,0,0,0,0,0,0,0}, olen: 1, o: '{9,0,0,0,0,0,0,0}, drop: 0, mode: 0};
        tbl[3] = '{len: 4, d: '{1,2,3,4,0,0,0,0}, olen: 4, o: '{1,2,3,4,0,0,0,0}, drop: 0, mode: 2};
        tbl[4] = '{len: 3, d: '{4,4,6,0,0,0,0,0}, olen: 2, o: '{4,6,0,0,0,0,0,0}, drop: 1, mode: 1};
        tbl[5] = '{len: 3, d: '{3,8,8,0,0,0,0,0}, olen: 2, o: '{3,8,0,0,0,0,0,0}, drop: 1, mode: 0};

        srst_i = 1'b1; snk_valid_i = 1'b0; snk_data_i = '0;
        snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(src_valid_o), 64'(0));
        check("rst_sop", 64'(src_startofpacket_o), 64'(0));
        check("rst_eop", 64'(src_endofpacket_o), 64'(0));
        check("rst_data", 64'(src_data_o), 64'(0));
        check("rst_drop", 64'(drop_cnt_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_snk_ready", 64'(snk_ready_o), 64'(1));
        srst_i = 1'b0;

        for (int t = 0; t < 6; t++) begin
            rdy_mode = tbl[t].mode;
            pkt_q.delete(); exp_q.delete();
            for (int i = 0; i < tbl[t].len; i++) pkt_q.push_back(tbl[t].d[i]);
            for (int i = 0; i < tbl[t].olen; i++)
                exp_q.push_back('{d: tbl[t].o[i], s: (i == 0), e: (i == tbl[t].olen - 1)});
            exp_drop = tbl[t].drop;
            run_pkt("vec");
        end

        // SOP inside an open packet closes it early and starts a new one.
        rdy_mode = 0; e0 = err_cnt; rcv.delete();
        send_word(1, 1, 0);
        send_word(2, 0, 0);
        send_word(8, 1, 0);
        check("sop_err_pulse", 64'(err_o), 64'(1));
        check("sop_drop_first", 64'(drop_cnt_o), 64'(0));
        send_word(8, 0, 1);
        wait_out(3);
        check("sop_count", 64'(rcv.size()), 64'(3));
        exp_q = '{'{d: 1, s: 1, e: 0}, '{d: 2, s: 0, e: 1}, '{d: 8, s: 1, e: 1}};
        foreach (exp_q[i]) if (i < rcv.size()) check("sop_beat", 64'(rcv[i]), 64'(exp_q[i]));
        check("sop_drop_second", 64'(drop_cnt_o), 64'(1));
        check("sop_err_count", 64'(err_cnt - e0), 64'(1));

        // Single-word packet: one FLUSH cycle with sink stalled, then output.
        rcv.delete();
        send_word(9, 1, 1);
        check("flush_snk_ready", 64'(snk_ready_o), 64'(0));
        check("flush_not_yet", 64'(src_valid_o), 64'(0));
        @(posedge clk_i); #1;
        check("single_out", 64'({src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o}),
              64'({1'b1, 32'd9, 1'b1, 1'b1}));
        check("single_drop", 64'(drop_cnt_o), 64'(0));
        check("idle_snk_ready", 64'(snk_ready_o), 64'(1));

        // Reset mid-packet discards the held and pending words.
        send_word(1, 1, 0);
        send_word(2, 0, 0);
        send_word(3, 0, 0);
        srst_i = 1'b1;
        @(posedge clk_i); #1;
        check("midrst_valid", 64'(src_valid_o), 64'(0));
        check("midrst_snk_ready", 64'(snk_ready_o), 64'(1));
        srst_i = 1'b0;
        pkt_q = '{6, 6};
        exp_q = '{'{d: 6, s: 1, e: 1}};
        exp_drop = 1;
        run_pkt("post_rst");
        repeat (5) begin @(posedge clk_i); #1; end
        check("post_rst_no_extra", 64'(rcv.size()), 64'(1));

        // Long all-equal packet saturates the duplicate counter.
        pkt_q.delete();
        repeat (70) pkt_q.push_back(32'd5);
        build_model();
        run_pkt("saturate");

        rdy_mode = 1;
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) send_word($urandom, 1'b0, 1'($urandom_range(0, 1)));
            len = $urandom_range(1, 12);
            v = $urandom_range(0, 50);
            pkt_q.delete();
            repeat (len) begin
                pkt_q.push_back(v);
                v += $urandom_range(0, 2);
            end
            build_model();
            run_pkt("rand");
        end

        check("total_err_pulses", 64'(err_cnt), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
